// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// State encoding and conversion sizing live here so all files agree.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CONV = 2'b01,
        FIN  = 2'b10
    } state_t;

    localparam int BIN_W       = 16;
    localparam int BCD_ND      = 5;
    localparam int SHIFT_STEPS = 16;
    localparam int CNT_W       = $clog2(SHIFT_STEPS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_STEPS - 1);

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction cell: add 3 when the digit is 5 or more.
// An input digit never exceeds 9, so the 4-bit sum cannot wrap.
module bcd_add3 (
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin_to_bcd16.sv
// Sequential shift-and-add-3 converter: 16-bit product to five BCD digits.
// Starts on a rising VALID edge, runs 16 shift steps, then pulses DONE.
module bin_to_bcd16
    import bcd_pkg::*;
#(
    parameter int W  = BIN_W,
    parameter int ND = BCD_ND
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            VALID,
    input  logic [W-1:0]    BIN,
    output logic [4*ND-1:0] BCD,
    output logic            DONE,
    output logic            BUSY
);

    localparam int AW = 4 * ND;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic          vprev_q;
    logic [W-1:0]  sh_q, sh_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] bcd_q, bcd_d;
    logic          done_q, done_d;

    logic            start;
    logic [AW-1:0]   acc_adj;
    logic [AW+W-1:0] shifted;

    assign start = VALID & ~vprev_q;

    for (genvar g = 0; g < ND; g++) begin : g_adj
        bcd_add3 u_add3 (
            .d_i (acc_q[4*g +: 4]),
            .q_o (acc_adj[4*g +: 4])
        );
    end

    assign shifted = {acc_adj, sh_q} << 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONV;
                    cnt_d   = '0;
                    sh_d    = BIN;
                    acc_d   = '0;
                end
            end
            CONV: begin
                cnt_d = cnt_q + 1'b1;
                sh_d  = shifted[W-1:0];
                acc_d = shifted[AW+W-1:W];
                if (cnt_q == CNT_LAST) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                bcd_d   = acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vprev_q <= 1'b0;
            sh_q    <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            vprev_q <= VALID;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign BCD  = bcd_q;
    assign DONE = done_q;
    assign BUSY = (state_q == CONV) || (state_q == FIN);

endmodule

// File: tb/tb_bin_to_bcd16.sv
// Randomized and directed bench for bin_to_bcd16 against a decimal model.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_bin_to_bcd16;

    logic        CLK;
    logic        RESET;
    logic        VALID;
    logic [15:0] BIN;
    logic [19:0] BCD;
    logic        DONE;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    bin_to_bcd16 dut (
        .CLK   (CLK),
        .RESET (RESET),
        .VALID (VALID),
        .BIN   (BIN),
        .BCD   (BCD),
        .DONE  (DONE),
        .BUSY  (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Start one conversion and watch `window` edges after the sampling edge.
    task automatic run_conv(
        input  logic [15:0] v,
        input  int          hold,
        input  int          window,
        output int          first,
        output int          ndone,
        output logic [19:0] res,
        output logic        busy1,
        output logic        busy_done
    );
        first     = -1;
        ndone     = 0;
        res       = '0;
        busy1     = 1'b0;
        busy_done = 1'b1;
        @(negedge CLK);
        BIN   = v;
        VALID = 1'b1;
        @(posedge CLK);
        for (int i = 1; i <= window; i++) begin
            @(posedge CLK);
            #1;
            if (i >= hold) VALID = 1'b0;
            if (i == 1) busy1 = BUSY;
            if (DONE) begin
                ndone++;
                if (first < 0) begin
                    first     = i;
                    res       = BCD;
                    busy_done = BUSY;
                end
            end
        end
    endtask

    task automatic test_reset();
        int          first, nd;
        logic [19:0] res;
        logic        b1, bd;
        RESET = 1'b1;
        VALID = 1'b0;
        BIN   = '0;
        #2;
        checks++;
        if (BCD !== 20'h0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got bcd=%h done=%b busy=%b expected 0/0/0",
                     BCD, DONE, BUSY);
        end
        @(negedge CLK);
        RESET = 1'b0;
        run_conv(16'd54321, 1, 20, first, nd, res, b1, bd);
        checks++;
        if (res !== 20'h54321) begin
            errors++;
            $display("FAIL pre_reset_conv: got %h expected 54321", res);
        end
        @(negedge CLK);
        BIN   = 16'd999;
        VALID = 1'b1;
        @(posedge CLK);
        repeat (8) @(posedge CLK);
        #1;
        VALID = 1'b0;
        #1;
        RESET = 1'b1;
        #1;
        checks++;
        if (BCD !== 20'h0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got bcd=%h done=%b busy=%b expected 0/0/0",
                     BCD, DONE, BUSY);
        end
        @(negedge CLK);
        RESET = 1'b0;
        nd = 0;
        repeat (30) begin
            @(posedge CLK);
            #1;
            if (DONE) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d pulses expected 0", nd);
        end
        @(negedge CLK);
        RESET = 1'b1;
        VALID = 1'b1;
        BIN   = 16'd4242;
        @(negedge CLK);
        RESET = 1'b0;
        first = -1;
        @(posedge CLK);
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK);
            #1;
            if (i >= 2) VALID = 1'b0;
            if (DONE && first < 0) begin
                first = i;
                res   = BCD;
            end
        end
        checks++;
        if (first !== 17 || res !== 20'h04242) begin
            errors++;
            $display("FAIL valid_at_release: got lat=%0d bcd=%h expected 17 04242",
                     first, res);
        end
    endtask

    task automatic test_small();
        int          first, nd;
        logic [19:0] res;
        logic        b1, bd;
        run_conv(16'd144, 1, 25, first, nd, res, b1, bd);
        checks++;
        if (first !== 17 || nd !== 1) begin
            errors++;
            $display("FAIL small_latency: got lat=%0d n=%0d expected 17 1", first, nd);
        end
        checks++;
        if (res !== 20'h00144) begin
            errors++;
            $display("FAIL small_value: got %h expected 00144", res);
        end
        checks++;
        if (b1 !== 1'b1 || bd !== 1'b0) begin
            errors++;
            $display("FAIL small_busy: got busy1=%b busy_at_done=%b expected 1 0", b1, bd);
        end
    endtask

    task automatic test_extremes();
        logic [15:0] vals [4];
        int          first, nd;
        logic [19:0] res;
        logic        b1, bd;
        vals = '{16'd0, 16'd65535, 16'd9999, 16'd10000};
        foreach (vals[k]) begin
            run_conv(vals[k], 1, 20, first, nd, res, b1, bd);
            checks++;
            if (first !== 17 || nd !== 1 || res !== ref_bcd(vals[k])) begin
                errors++;
                $display("FAIL extreme_%0d: got lat=%0d n=%0d bcd=%h expected 17 1 %h",
                         vals[k], first, nd, res, ref_bcd(vals[k]));
            end
        end
    endtask

    task automatic test_held_valid();
        int          first, nd;
        logic [19:0] res;
        logic        b1, bd;
        run_conv(16'd255, 40, 45, first, nd, res, b1, bd);
        checks++;
        if (nd !== 1 || res !== 20'h00255) begin
            errors++;
            $display("FAIL held_valid: got n=%0d bcd=%h expected 1 00255", nd, res);
        end
    endtask

    task automatic test_busy_edge();
        int          first, nd;
        logic [19:0] res;
        first = -1;
        nd    = 0;
        res   = '0;
        @(negedge CLK);
        BIN   = 16'd1234;
        VALID = 1'b1;
        @(posedge CLK);
        for (int i = 1; i <= 50; i++) begin
            @(posedge CLK);
            #1;
            if (i == 3) VALID = 1'b0;
            if (i == 5) begin
                VALID = 1'b1;
                BIN   = 16'd4321;
            end
            if (i == 7) VALID = 1'b0;
            if (DONE) begin
                nd++;
                if (first < 0) begin
                    first = i;
                    res   = BCD;
                end
            end
        end
        checks++;
        if (nd !== 1 || first !== 17 || res !== 20'h01234) begin
            errors++;
            $display("FAIL busy_edge: got n=%0d lat=%0d bcd=%h expected 1 17 01234",
                     nd, first, res);
        end
    endtask

    task automatic test_back_to_back();
        int          d1, d2, nd;
        logic [19:0] r1, r2;
        d1 = -1;
        d2 = -1;
        nd = 0;
        r1 = '0;
        r2 = '0;
        @(negedge CLK);
        BIN   = 16'd100;
        VALID = 1'b1;
        @(posedge CLK);
        for (int i = 1; i <= 45; i++) begin
            @(posedge CLK);
            #1;
            if (i == 1) VALID = 1'b0;
            if (i == 17) begin
                VALID = 1'b1;
                BIN   = 16'd7;
            end
            if (i == 19) VALID = 1'b0;
            if (DONE) begin
                nd++;
                if (d1 < 0) begin
                    d1 = i;
                    r1 = BCD;
                end else if (d2 < 0) begin
                    d2 = i;
                    r2 = BCD;
                end
            end
        end
        checks++;
        if (nd !== 2 || d1 !== 17 || d2 !== 35) begin
            errors++;
            $display("FAIL b2b_timing: got n=%0d d1=%0d d2=%0d expected 2 17 35",
                     nd, d1, d2);
        end
        checks++;
        if (r1 !== 20'h00100 || r2 !== 20'h00007) begin
            errors++;
            $display("FAIL b2b_values: got %h %h expected 00100 00007", r1, r2);
        end
    endtask

    task automatic test_random();
        int          first, nd;
        logic [19:0] res;
        logic        b1, bd;
        logic [15:0] v;
        for (int n = 0; n < 24; n++) begin
            v = 16'($urandom_range(0, 65535));
            run_conv(v, 1 + (n % 3), 20, first, nd, res, b1, bd);
            checks++;
            if (first !== 17 || nd !== 1 || res !== ref_bcd(v)) begin
                errors++;
                $display("FAIL random_%0d: bin=%0d got lat=%0d n=%0d bcd=%h expected 17 1 %h",
                         n, v, first, nd, res, ref_bcd(v));
            end
        end
    endtask

    initial begin
        test_reset();
        test_small();
        test_extremes();
        test_held_valid();
        test_busy_edge();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
